// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a window of 2^WIDTH accepted
// samples and hands the count downstream through a ready/valid port.
module sc_stream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH:0]   out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] r_samp_cnt;
  logic [WIDTH:0]   r_ones_cnt;
  logic [WIDTH:0]   r_out_value;
  logic             r_out_valid;
  logic             r_overrun;

  logic             w_accept;
  logic             w_last;
  logic             w_complete;
  logic             w_xfer;
  logic [WIDTH:0]   w_bit_ext;
  logic [WIDTH:0]   w_ones_next;

  // clear takes priority over in_valid, so a coincident sample is dropped
  assign w_accept    = in_valid & ~clear;
  assign w_last      = &r_samp_cnt;
  assign w_complete  = w_accept & w_last;
  assign w_xfer      = r_out_valid & out_ready;
  assign w_bit_ext   = {{WIDTH{1'b0}}, in_bit};
  assign w_ones_next = r_ones_cnt + w_bit_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_cnt  <= '0;
      r_ones_cnt  <= '0;
      r_out_value <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (clear || w_complete) begin
        r_samp_cnt <= '0;
        r_ones_cnt <= '0;
      end else if (w_accept) begin
        r_samp_cnt <= r_samp_cnt + 1'b1;
        r_ones_cnt <= w_ones_next;
      end

      // A completion always wins the output register; overrun only when the old result was never taken
      if (w_complete) begin
        r_out_value <= w_ones_next;
        r_out_valid <= 1'b1;
        if (r_out_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_value = r_out_value;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard bench for sc_stream_decoder (WIDTH=4): a window-sum model pushes
// expected results, and a monitor pops and compares them on each transfer.
module tb_sc_stream_decoder;

  localparam int WIDTH = 4;
  localparam int WIN   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_bit;
  logic             in_valid;
  logic             clear;
  logic [WIDTH:0]   out_value;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  int checks = 0;
  int passes = 0;

  int expQ[$];
  bit expOverrun = 1'b0;
  int accCount = 0;
  int onesSum = 0;
  bit monOn = 1'b0;

  sc_stream_decoder #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .clear(clear),
    .out_value(out_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle, then advance the reference model to match the clock edge just taken
  task automatic applyStimulus(input bit b, input bit v, input bit c, input bit rdy, input bit r);
    in_bit    = b;
    in_valid  = v;
    clear     = c;
    out_ready = rdy;
    rst       = r;
    @(posedge clk);
    if (r) begin
      expQ.delete();
      expOverrun = 1'b0;
      accCount = 0;
      onesSum = 0;
    end else if (c) begin
      accCount = 0;
      onesSum = 0;
    end else if (v) begin
      onesSum += int'(b);
      accCount++;
      if (accCount == WIN) begin
        if (expQ.size() > 0) begin
          void'(expQ.pop_back());
          expOverrun = 1'b1;
        end
        expQ.push_back(onesSum);
        accCount = 0;
        onesSum = 0;
      end
    end
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_value", int'(out_value), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
  endtask

  // Feed n accepted samples, the first `ones` of them being 1
  task automatic feedWindow(input int n, input int ones, input bit rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(i < ones, 1'b1, 1'b0, rdy, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (monOn && !rst) begin
      checkOutput("out_valid", int'(out_valid), int'(expQ.size() != 0));
      checkOutput("overrun", int'(overrun), int'(expOverrun));
      if (out_valid && expQ.size() != 0) begin
        checkOutput("out_value", int'(out_value), expQ[0]);
        if (out_ready) begin
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    in_bit = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    doReset();
    monOn = 1'b1;

    // All ones with consumer always ready
    feedWindow(WIN, WIN, 1'b1);
    checkOutput("all_ones_value", int'(out_value), 16);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("all_ones_drop", int'(out_valid), 0);

    // Gapped input: invalid cycles carry in_bit=1
    doReset();
    for (int k = 0; k < WIN; k++) begin
      applyStimulus(k % 2 == 0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k != WIN - 1) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("gapped_value", int'(out_value), 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back windows with stalled consumer
    doReset();
    feedWindow(WIN, 3, 1'b0);
    checkOutput("stall_w1", int'(out_value), 3);
    feedWindow(WIN, 12, 1'b0);
    checkOutput("stall_w2", int'(out_value), 12);
    checkOutput("stall_ovr", int'(overrun), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_drop", int'(out_valid), 0);
    checkOutput("stall_ovr_sticky", int'(overrun), 1);

    // Completion coincident with transfer
    doReset();
    feedWindow(WIN, 5, 1'b0);
    feedWindow(WIN - 1, 8, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("coinc_value", int'(out_value), 9);
    checkOutput("coinc_valid", int'(out_valid), 1);
    checkOutput("coinc_ovr", int'(overrun), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-window, then an all-zero window
    feedWindow(7, 7, 1'b1);
    doReset();
    feedWindow(WIN - 1, 0, 1'b1);
    checkOutput("rst_mid_early", int'(out_valid), 0);
    feedWindow(1, 0, 1'b1);
    checkOutput("rst_mid_valid", int'(out_valid), 1);
    checkOutput("rst_mid_value", int'(out_value), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear mid-window keeps the pending result
    doReset();
    feedWindow(WIN, 7, 1'b0);
    feedWindow(10, 10, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_keep", int'(out_value), 7);
    feedWindow(WIN, 4, 1'b0);
    checkOutput("clear_value", int'(out_value), 4);
    checkOutput("clear_ovr", int'(overrun), 1);

    // Randomized traffic against the model
    doReset();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 999) < 3);
    end

    monOn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
